// File: rtl/sram_bank_sequencer.sv
// Bennett phase-clock sequencer for the 2-port SRAM bank: generates the phase clocks,
// queues read/write requests and plays one request per frame into the bank.
module sram_bank_sequencer #(
    parameter int PHASES   = 10,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int QDEPTH   = 4,
    parameter int ADDR_PH  = 2,
    parameter int DATA_PH  = 4,
    parameter int READ_PH  = 6,
    parameter int WRITE_PH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_data,
    input  logic              pause,
    input  logic [DATA_W-1:0] sram_outA,
    input  logic [DATA_W-1:0] sram_outB,
    output logic [PHASES-1:0] clkp,
    output logic              Mclk,
    output logic              instFlag,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] din,
    output logic              ReadEn,
    output logic              WriteEn,
    output logic              RegWrtBar,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b
);

    localparam int STEPS = 2 * PHASES;
    localparam int SW    = $clog2(STEPS);
    localparam int PW    = $clog2(QDEPTH);

    localparam logic [SW-1:0] LAST_STEP  = SW'(STEPS - 1);
    localparam logic [SW-1:0] PEAK_STEP  = SW'(PHASES - 1);
    localparam logic [SW-1:0] RSP_STEP   = SW'(PHASES);
    localparam logic [SW-1:0] ADDR_STEP  = SW'(ADDR_PH);
    localparam logic [SW-1:0] DATA_STEP  = SW'(DATA_PH);
    localparam logic [SW-1:0] READ_STEP  = SW'(READ_PH);
    localparam logic [SW-1:0] READ_END   = SW'(WRITE_PH - 1);
    localparam logic [SW-1:0] WRITE_STEP = SW'(WRITE_PH);
    localparam logic [SW-1:0] WBAR_END   = SW'(STEPS - 1 - READ_PH);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    logic              r_running;
    logic [SW-1:0]     r_step;
    op_e               r_opKind;
    logic [ADDR_W-1:0] r_opAddrA;
    logic [ADDR_W-1:0] r_opAddrB;
    logic [DATA_W-1:0] r_opData;

    logic [ADDR_W-1:0] r_addrA;
    logic [ADDR_W-1:0] r_addrB;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_rspA;
    logic [DATA_W-1:0] r_rspB;

    logic              r_fifoWrite [QDEPTH];
    logic [ADDR_W-1:0] r_fifoAddrA [QDEPTH];
    logic [ADDR_W-1:0] r_fifoAddrB [QDEPTH];
    logic [DATA_W-1:0] r_fifoData  [QDEPTH];
    logic [PW:0]       r_wrPtr;
    logic [PW:0]       r_rdPtr;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_hold;
    logic              w_frameLoad;
    logic [SW-1:0]     w_stepNext;
    op_e               w_headKind;
    op_e               w_nextKind;
    logic [ADDR_W-1:0] w_nextAddrA;
    logic [ADDR_W-1:0] w_nextAddrB;
    logic [DATA_W-1:0] w_nextData;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty     = (r_wrPtr == r_rdPtr);
    assign w_full      = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_push      = req_valid && !w_full;
    assign w_hold      = r_running && (r_step == PEAK_STEP) && pause;
    assign w_frameLoad = !r_running || (r_step == LAST_STEP);
    assign w_pop       = w_frameLoad && !w_empty;
    assign w_headKind  = r_fifoWrite[r_rdPtr[PW-1:0]] ? OP_WRITE : OP_READ;

    always_comb begin
        w_stepNext = r_step;
        if (!r_running || r_step == LAST_STEP) begin
            w_stepNext = '0;
        end else if (!w_hold) begin
            w_stepNext = r_step + SW'(1);
        end
    end

    // The op seen by the next cycle, so step-aligned output updates work even at step 0.
    always_comb begin
        w_nextKind  = r_opKind;
        w_nextAddrA = r_opAddrA;
        w_nextAddrB = r_opAddrB;
        w_nextData  = r_opData;
        if (w_frameLoad) begin
            if (w_empty) begin
                w_nextKind = OP_NOP;
            end else begin
                w_nextKind  = w_headKind;
                w_nextAddrA = r_fifoAddrA[r_rdPtr[PW-1:0]];
                w_nextAddrB = r_fifoAddrB[r_rdPtr[PW-1:0]];
                w_nextData  = r_fifoData[r_rdPtr[PW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoWrite[r_wrPtr[PW-1:0]] <= req_write;
            r_fifoAddrA[r_wrPtr[PW-1:0]] <= req_addr_a;
            r_fifoAddrB[r_wrPtr[PW-1:0]] <= req_addr_b;
            r_fifoData[r_wrPtr[PW-1:0]]  <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + (PW + 1)'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_running <= 1'b0;
            r_step    <= '0;
            r_opKind  <= OP_NOP;
            r_opAddrA <= '0;
            r_opAddrB <= '0;
            r_opData  <= '0;
            r_addrA   <= '0;
            r_addrB   <= '0;
            r_din     <= '0;
            r_rspA    <= '0;
            r_rspB    <= '0;
        end else begin
            r_running <= 1'b1;
            r_step    <= w_stepNext;
            r_opKind  <= w_nextKind;
            r_opAddrA <= w_nextAddrA;
            r_opAddrB <= w_nextAddrB;
            r_opData  <= w_nextData;
            if (w_stepNext == ADDR_STEP && w_nextKind != OP_NOP) begin
                r_addrA <= w_nextAddrA;
                r_addrB <= w_nextAddrB;
            end
            if (w_stepNext == DATA_STEP && w_nextKind == OP_WRITE) begin
                r_din <= w_nextData;
            end
            // Capture only on the cycle that actually leaves the peak, i.e. the last paused cycle.
            if (r_running && r_step == PEAK_STEP && !pause && r_opKind == OP_READ) begin
                r_rspA <= sram_outA;
                r_rspB <= sram_outB;
            end
        end
    end

    always_comb begin
        clkp = '0;
        for (int i = 0; i < PHASES; i++) begin
            clkp[i] = r_running && (i <= int'(r_step)) && (int'(r_step) <= STEPS - 1 - i);
        end
    end

    assign Mclk      = r_running && (r_step < RSP_STEP);
    assign instFlag  = r_running && (r_step == '0);
    assign ReadEn    = r_running && (r_opKind == OP_READ) && (r_step >= READ_STEP) && (r_step <= READ_END);
    assign WriteEn   = r_running && (r_opKind == OP_WRITE) && (r_step == WRITE_STEP);
    assign RegWrtBar = r_running && (r_opKind == OP_WRITE) && (r_step >= READ_STEP) && (r_step <= WBAR_END);
    assign rsp_valid = r_running && (r_opKind == OP_READ) && (r_step == RSP_STEP);
    assign req_ready = !w_full;
    assign Addr_A    = r_addrA;
    assign Addr_B    = r_addrB;
    assign din       = r_din;
    assign rsp_a     = r_rspA;
    assign rsp_b     = r_rspB;

endmodule

// File: doc/sram_bank_sequencer.md
Name: sram_bank_sequencer

Overview:
- Parametrised successor to the fixed 10-phase bench sequencing of the 2-port SRAM bank.
- Generates a PHASES-phase Bennett square clock set, Mclk and instFlag, and drives Addr_A, Addr_B, din, ReadEn, RegWrtBar and WriteEn at configurable phases.
- Accepts queued read/write requests and returns read data.
- Sits between the core's register-file request path and sram_2port_bank.

Parameters:
PHASES, 10, number of Bennett phases; one frame = 2*PHASES cycles
ADDR_W, 5, SRAM address width
DATA_W, 16, SRAM data width
QDEPTH, 4, request FIFO depth (power of 2, >=2)
ADDR_PH, 2, step at which addresses are driven
DATA_PH, 4, step at which write data is driven
READ_PH, 6, first step of the ReadEn window and the RegWrtBar rise step
WRITE_PH, 8, step of the WriteEn pulse (READ_PH < WRITE_PH < PHASES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (= !full)
req_write  in  1  1 = write, 0 = read
req_addr_a  in  ADDR_W  write / port-A address
req_addr_b  in  ADDR_W  port-B read address
req_data  in  DATA_W  write data
pause  in  1  hold the frame at peak
sram_outA  in  DATA_W  bank port-A data
sram_outB  in  DATA_W  bank port-B data
clkp  out  PHASES  Bennett phase clocks (clkneg = ~clkp, formed outside)
Mclk  out  1  high during the ramp-up half
instFlag  out  1  one-cycle pulse at step 0
Addr_A, Addr_B  out  ADDR_W  bank addresses
din  out  DATA_W  bank write data
ReadEn, WriteEn, RegWrtBar  out  1  bank controls
rsp_valid  out  1  one-cycle read-response strobe
rsp_a, rsp_b  out  DATA_W  captured read data

Behaviour:
- Reset (clk edge with reset=1):
  - running=0, step=0, FIFO emptied, active op = NOP.
  - All outputs 0 except req_ready=1.
- While running=0, every output is 0 except req_ready.
- First edge with reset=0 sets running=1 and step=0; frame 0 begins the following cycle.
- Step counter s runs 0..2P-1 (P=PHASES) and wraps to 0. It never skips a step.
- clkp[i] = running && (i <= s) && (s <= 2P-1-i). So phase i rises at step i and falls at step 2P-i.
- Mclk = running && s < P. instFlag = running && s == 0.
- Pause: with pause=1 at an edge where s == P-1, s holds and all phases stay high. pause has no effect at any other step.
- Frame load: at the edge into step 0, pop the FIFO head into the active op, or load a NOP if the FIFO is empty.
- Addr_A/Addr_B update to the active op at step ADDR_PH and hold until the next frame's ADDR_PH. They also hold through NOP frames.
- din updates at step DATA_PH on write frames only; otherwise it holds.
- Write frame:
  - RegWrtBar=1 for steps READ_PH .. 2P-1-READ_PH.
  - WriteEn=1 at step WRITE_PH only.
  - ReadEn stays 0.
- Read frame:
  - ReadEn=1 for steps READ_PH .. WRITE_PH-1.
  - sram_outA/outB are captured at the end of step P-1, the final cycle of any pause.
  - rsp_valid=1 for exactly one cycle at step P, with rsp_a/rsp_b holding the captured values until the next capture.
- NOP frame: ReadEn, WriteEn and RegWrtBar all 0; rsp_valid stays 0.
- FIFO:
  - Push when req_valid && req_ready.
  - Push and pop in the same cycle are both honoured.
  - A push while full is ignored; req_ready is 0 then.
  - Order is strict FIFO; pointers wrap modulo QDEPTH.
- Reset mid-frame: the next cycle has every clkp at 0 and all enables dropped; pending requests are discarded and no rsp_valid is issued.
- Outputs are glitch-free: each is registered or decoded from registered s/running/op only.

Test Plan:
- Reset release, no requests, P=10: clkp[0] rises 2 cycles after release, clkp[9] high only at steps 9-10, cycle period 20; Mclk high steps 0-9; no enables asserted.
- Write addr_a=5'h1F, data=16'hAAAA: Addr_A=1F from step 2, din=AAAA from step 4, RegWrtBar high steps 6-13, WriteEn high step 8 only.
- After that write, read addr_a=5'h1F, addr_b=5'h00 with the bench SRAM model: ReadEn high steps 6-7, rsp_valid at step 10, rsp_a=16'hAAAA.
- Push 5 requests back-to-back with QDEPTH=4: req_ready drops after the 4th push, the 5th is ignored until a pop, and the 4 ops execute in order in 4 consecutive frames.
- Hold pause=1 for 7 cycles in a read frame: s stays at 9 for 8 cycles, all clkp stay high, and rsp_valid still fires exactly once.
- Assert reset at step 12 of a write frame: the next cycle has clkp=0 and WriteEn/RegWrtBar=0, the FIFO is empty, and a clean frame restarts after release.
